// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule controller: steps the key memory through times 0..10 once per key
// and caches every round key for random 1-cycle reads. Optional macro: AES_KEYCTRL_REUSE_EN.
module aes_key_sched_ctrl #(
  parameter int KEY_W  = 128,
  parameter int ROUNDS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  output logic [KEY_W-1:0] km_key,
  output logic [3:0]       km_times,
  input  logic [KEY_W-1:0] km_keyout,
  output logic             keys_valid,
  output logic             expand_done,
  input  logic             rd_en,
  input  logic [3:0]       rd_idx,
  output logic             rd_vld,
  output logic [KEY_W-1:0] rd_data
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXPAND,
    READY
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(ROUNDS);

  state_t           state;
  logic [KEY_W-1:0] cache [0:ROUNDS];
  logic             key_acc;
  logic             rd_acc;
  logic             reuse_hit;

  assign key_ready = (state == IDLE) || (state == READY);
  assign key_acc   = key_valid & key_ready;
  assign rd_acc    = rd_en & keys_valid;

`ifdef AES_KEYCTRL_REUSE_EN
  // The key memory already holds this key's schedule, so skip the re-expansion.
  assign reuse_hit = (state == READY) && (key_in == km_key);
`else
  assign reuse_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      km_key      <= '0;
      km_times    <= '0;
      keys_valid  <= 1'b0;
      expand_done <= 1'b0;
      rd_vld      <= 1'b0;
      rd_data     <= '0;
      // NOTE: the cache is reset too, so a reset mid-expansion leaves no stale round keys behind.
      for (int i = 0; i <= ROUNDS; i++) cache[i] <= '0;
    end else begin
      expand_done <= 1'b0;
      rd_vld      <= rd_acc;

      // A read on the same edge as a key accept sees the old schedule (non-blocking update).
      if (rd_acc) rd_data <= (rd_idx > LAST_IDX) ? '0 : cache[rd_idx];

      case (state)
        IDLE, READY: begin
          if (key_acc) begin
            if (reuse_hit) begin
              expand_done <= 1'b1;
            end else begin
              km_key     <= key_in;
              cache[0]   <= key_in;
              km_times   <= 4'd0;
              keys_valid <= 1'b0;
              state      <= LOAD;
            end
          end
        end
        LOAD: begin
          km_times <= 4'd1;
          state    <= EXPAND;
        end
        EXPAND: begin
          cache[km_times] <= km_keyout;
          if (km_times == LAST_IDX) begin
            keys_valid  <= 1'b1;
            expand_done <= 1'b1;
            state       <= READY;
          end else begin
            km_times <= km_times + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
